// File: rtl/dvi_pkg.sv
// Shared types and default 640x480@60 timing for the DVI video path.
package dvi_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam bit          DEF_H_POL    = 1'b0;
    localparam bit          DEF_V_POL    = 1'b0;

    // Bar order white..black is a binary down-count on {G,R,B}.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.r = {8{~idx[1]}};
        c.g = {8{~idx[2]}};
        c.b = {8{~idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/test_pattern_gen.sv
// Test-pattern colour for the current counter position; combinational apart
// from the colour-bar sub-counter that follows the line counter.
module test_pattern_gen
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
    parameter int unsigned XW       = $clog2(H_TOTAL)
) (
    input  logic          pixel_clk_i,
    input  logic          rst_i,
    input  logic [XW-1:0] h_i,
    input  logic [7:0]    y_i,
    input  logic          de_i,
    input  pattern_e      sel_i,
    input  rgb_t          solid_i,
    output rgb_t          rgb_o
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);

    logic [XW-1:0] bar_px_q, bar_px_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [7:0]    x8;

    assign x8 = 8'(h_i);

    // Bar position advances with h and restarts with every line, so no divider is needed.
    always_comb begin
        bar_px_d  = bar_px_q + XW'(1);
        bar_idx_d = bar_idx_q;
        if (h_i == H_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == BAR_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end
    end

    // Bar sub-counter state.
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Pattern select; blanking is forced black here.
    always_comb begin
        rgb_o = '0;
        if (de_i) begin
            unique case (sel_i)
                PAT_BARS:  rgb_o = bar_colour(bar_idx_q);
                PAT_CHECK: rgb_o = (x8[5] ^ y_i[5]) ? '1 : '0;
                PAT_GRAD: begin
                    rgb_o.r = x8;
                    rgb_o.g = y_i;
                    rgb_o.b = x8 + y_i;
                end
                PAT_SOLID: rgb_o = solid_i;
            endcase
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source feeding the DVI encoders. Every output
// is registered from the same counter state, giving one cycle of latency.
module video_timing_gen
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = DEF_H_POL,
    parameter bit          V_POL    = DEF_V_POL,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          pixel_clk_i,
    input  logic          rst_i,
    input  logic [1:0]    pattern_sel_i,
    input  logic [23:0]   solid_rgb_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          frame_start_o,
    output logic [7:0]    red_o,
    output logic [7:0]    green_o,
    output logic [7:0]    blue_o
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic          origin, de_c, hs_c, vs_c;
    pattern_e      sel_q, sel_c;
    rgb_t          solid_q, solid_c, pat_rgb;
    logic [7:0]    y8;

    // Raster counter next state.
    always_comb begin
        h_d = h_q + XW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
        end
    end

    // Position decode for the pixel presented at the next edge.
    always_comb begin
        origin = (h_q == '0) && (v_q == '0);
        de_c   = (h_q < H_ACT) && (v_q < V_ACT);
        hs_c   = (h_q >= HS_START) && (h_q < HS_END);
        vs_c   = (v_q >= VS_START) && (v_q < VS_END);
        // Pixel (0,0) already uses the newly sampled selection.
        sel_c   = origin ? pattern_e'(pattern_sel_i) : sel_q;
        solid_c = origin ? rgb_t'(solid_rgb_i) : solid_q;
    end

    // Raster counters.
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Pattern selection is latched once per frame to avoid tearing.
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            sel_q   <= PAT_BARS;
            solid_q <= '0;
        end else if (origin) begin
            sel_q   <= sel_c;
            solid_q <= solid_c;
        end
    end

    assign y8 = 8'(v_q);

    test_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .XW       (XW)
    ) u_pattern (
        .pixel_clk_i (pixel_clk_i),
        .rst_i       (rst_i),
        .h_i         (h_q),
        .y_i         (y8),
        .de_i        (de_c),
        .sel_i       (sel_c),
        .solid_i     (solid_c),
        .rgb_o       (pat_rgb)
    );

    // Output register: all outputs describe the same (h, v).
    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            de_o          <= 1'b0;
            hsync_o       <= ~H_POL;
            vsync_o       <= ~V_POL;
            x_o           <= '0;
            y_o           <= '0;
            frame_start_o <= 1'b0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
        end else begin
            de_o          <= de_c;
            hsync_o       <= hs_c ? H_POL : ~H_POL;
            vsync_o       <= vs_c ? V_POL : ~V_POL;
            x_o           <= de_c ? h_q : '0;
            y_o           <= de_c ? v_q : '0;
            frame_start_o <= origin;
            red_o         <= pat_rgb.r;
            green_o       <= pat_rgb.g;
            blue_o        <= pat_rgb.b;
        end
    end

endmodule
